nic_vc_out_scheduler: RTL and testbench
=======================================

Name: nic_vc_out_scheduler

Overview:
NIC-side output scheduler toward the NoC router. It accepts whole packets from the msg-to-pkt stage, allocates a free virtual channel within the packet's vnet, and streams the flits onto the router link one per cycle. It tracks per-VC credits and busy state from the router's credit_signal/free_signal. It is the transmit-side counterpart of the NIC input port and its per-VC flits buffers.

Parameters:
N_VNET, 3, number of virtual networks
N_OF_VC, 2, VCs per vnet
N_TOT_OF_VC, 6, N_VNET*N_OF_VC
N_BITS_POINTER, 3, clog2(N_TOT_OF_VC)
N_BITS_VNET, 2, clog2(N_VNET)
FLIT_WIDTH, 64, flit width in bits
MAX_PACKET_LENGHT, 5, max flits per packet
N_BITS_LEN, 3, width of packet length field
CREDIT_DEPTH, 4, router buffer slots per VC (initial credits)
N_BITS_CREDIT, 3, credit counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
r_pkt_i  in  1  upstream has a packet ready
vnet_i  in  N_BITS_VNET  vnet of offered packet
pkt_len_i  in  N_BITS_LEN  flit count of offered packet
in_link_i  in  MAX_PACKET_LENGHT*FLIT_WIDTH  packet; flit 0 (head/head_tail) at bit 0, flit k at bit k*FLIT_WIDTH
g_pkt_o  out  1  grant: packet captured this cycle
out_link_o  out  FLIT_WIDTH  flit to router
is_valid_o  out  1  out_link_o valid
out_vc_o  out  N_BITS_POINTER  global VC of current flit = vnet*N_OF_VC+vc
credit_signal_i  in  N_TOT_OF_VC  per-VC credit return (one slot freed)
free_signal_i  in  N_TOT_OF_VC  per-VC router buffer went idle
vc_busy_o  out  N_TOT_OF_VC  per-VC allocated flag

Behaviour:
- Reset (async, immediate): state IDLE; out_link_o=0, is_valid_o=0, out_vc_o=0, g_pkt_o=0, vc_busy_o=0; all credits=CREDIT_DEPTH; flit index=0; RR pointers=0. A reset mid-packet aborts the packet; no further flits are sent.
- Eligible VC v: belongs to vnet_i, vc_busy[v]=0, credit[v]>0. vnet_i>=N_VNET → no VC is eligible.
- States: IDLE, SEND.
- IDLE: g_pkt_o = r_pkt_i & (any eligible VC) (combinational, same cycle). On that edge:
  - latch in_link_i, len, and the chosen VC.
  - set vc_busy[v].
  - load flit 0 into out_link_o; is_valid_o<=1; credit[v]--.
  - if len==1, stay IDLE; else go SEND with index=1.
  - Upstream may change its inputs from the next cycle.
- Length rule: pkt_len_i==0 is treated as 1; values >MAX_PACKET_LENGHT are treated as MAX_PACKET_LENGHT.
- SEND: each edge with credit[v]>0, emit flit[index], is_valid_o<=1, credit[v]--, index++. When credit[v]==0, is_valid_o<=0 (stall) and index holds. After the last flit, go to IDLE.
- IDLE sets is_valid_o<=0 when no grant. out_link_o/out_vc_o hold their last value while is_valid_o=0.
- Latency: grant in cycle t → head valid in cycle t+1. Back-to-back packets have one idle bubble between the tail and the next head.
- Credits: +1 on credit_signal_i[v], −1 on send. Both in the same cycle → unchanged. Increment at CREDIT_DEPTH saturates (ignored).
- Busy: cleared on free_signal_i[v]. A free arriving on the same edge as an allocation of that VC is ignored (set wins).
- Only one packet is in flight at a time; g_pkt_o=0 throughout SEND.

Optional Feature:
- Macro: NIC_VC_ALLOC_RR_EN.
- Defined: a per-vnet round-robin pointer (width clog2(N_OF_VC)) selects the first eligible VC at or after the pointer. After each grant in that vnet, the pointer moves to chosen+1 (wraps to 0).
- Undefined: fixed priority, lowest-index eligible VC in the vnet; no pointer registers.

Test Plan:
- Reset, then r_pkt_i=1, vnet_i=1, pkt_len_i=3 → g_pkt_o=1 in cycle t; flits 0,1,2 valid in t+1..t+3 with out_vc_o=2; vc_busy_o=6'b000100; credit[2]=1.
- Same VC, 5-flit packet, no credit returns → 4 flits sent, is_valid_o=0 stall. Pulse credit_signal_i[2] → flit 4 sent on the next edge, then IDLE.
- Credit return and send on the same cycle for VC 0 → credit unchanged at 3. Credit_signal at 4 credits → stays 4.
- Both VCs of vnet 0 busy, r_pkt_i=1 vnet_i=0 → g_pkt_o=0 indefinitely. free_signal_i[1] pulse → grant next cycle on VC 1.
- With NIC_VC_ALLOC_RR_EN: two vnet-2 packets, VC 5 freed between them → VC 4 then VC 5. Without the macro → VC 4 both times (after free_signal_i[4]).
- Assert rst during flit 2 of 4 → is_valid_o=0 immediately, credits=4, vc_busy_o=0; a new packet is accepted normally after deassertion.

Source files
------------

// File: rtl/nic_vc_out_scheduler_if.sv
// Link bundle between the msg-to-pkt stage, the router and the VC scheduler.
// master drives packets and router feedback; slave is the scheduler.
interface nic_vc_out_scheduler_if #(
  parameter int N_TOT_OF_VC       = 6,
  parameter int N_BITS_POINTER    = 3,
  parameter int N_BITS_VNET       = 2,
  parameter int FLIT_WIDTH        = 64,
  parameter int MAX_PACKET_LENGHT = 5,
  parameter int N_BITS_LEN        = 3
);
  logic                                    r_pkt_i;
  logic [N_BITS_VNET-1:0]                  vnet_i;
  logic [N_BITS_LEN-1:0]                   pkt_len_i;
  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i;
  logic                                    g_pkt_o;
  logic [FLIT_WIDTH-1:0]                   out_link_o;
  logic                                    is_valid_o;
  logic [N_BITS_POINTER-1:0]               out_vc_o;
  logic [N_TOT_OF_VC-1:0]                  credit_signal_i;
  logic [N_TOT_OF_VC-1:0]                  free_signal_i;
  logic [N_TOT_OF_VC-1:0]                  vc_busy_o;

  modport master (
    output r_pkt_i, vnet_i, pkt_len_i, in_link_i,
    output credit_signal_i, free_signal_i,
    input  g_pkt_o, out_link_o, is_valid_o, out_vc_o, vc_busy_o
  );

  modport slave (
    input  r_pkt_i, vnet_i, pkt_len_i, in_link_i,
    input  credit_signal_i, free_signal_i,
    output g_pkt_o, out_link_o, is_valid_o, out_vc_o, vc_busy_o
  );
endinterface

// File: rtl/nic_vc_out_scheduler.sv
// NIC output scheduler: VC allocation, per-VC credits, flit streaming.
// NIC_VC_ALLOC_RR_EN: round-robin VC pick per vnet (else lowest index).
module nic_vc_out_scheduler #(
  parameter int N_VNET            = 3,
  parameter int N_OF_VC           = 2,
  parameter int N_TOT_OF_VC       = 6,
  parameter int N_BITS_POINTER    = 3,
  parameter int N_BITS_VNET       = 2,
  parameter int FLIT_WIDTH        = 64,
  parameter int MAX_PACKET_LENGHT = 5,
  parameter int N_BITS_LEN        = 3,
  parameter int CREDIT_DEPTH      = 4,
  parameter int N_BITS_CREDIT     = 3
) (
  input logic clk,
  input logic rst,
  nic_vc_out_scheduler_if.slave bus
);
  localparam int NP  = N_BITS_POINTER;
  localparam int NRR = (N_OF_VC > 1) ? $clog2(N_OF_VC) : 1;
  localparam int NIX = $clog2(MAX_PACKET_LENGHT + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state_q, state_d;

  logic [FLIT_WIDTH-1:0]    pkt_q [MAX_PACKET_LENGHT];
  logic [NIX-1:0]           len_q, idx_q, eff_len;
  logic [NP-1:0]            vc_q, base, sel, gv, dec_vc;
  logic [N_BITS_CREDIT-1:0] credit_q [N_TOT_OF_VC];
  logic [N_TOT_OF_VC-1:0]   busy_q, dec_mask, set_mask;
  logic [FLIT_WIDTH-1:0]    out_link_q;
  logic                     valid_q;
  logic [NP-1:0]            out_vc_q;
  logic [N_OF_VC-1:0]       elig;
  logic [NRR-1:0]           sel_loc;
  logic                     vnet_ok, grant, send, last;

  assign bus.g_pkt_o    = grant & ~rst;
  assign bus.out_link_o = out_link_q;
  assign bus.is_valid_o = valid_q;
  assign bus.out_vc_o   = out_vc_q;
  assign bus.vc_busy_o  = busy_q;

  // clamp the offered length into 1..MAX_PACKET_LENGHT
  always_comb begin
    if (bus.pkt_len_i == '0)
      eff_len = NIX'(1);
    else if (int'(bus.pkt_len_i) > MAX_PACKET_LENGHT)
      eff_len = NIX'(MAX_PACKET_LENGHT);
    else
      eff_len = NIX'(bus.pkt_len_i);
  end

  // VCs of the offered vnet that are idle and hold a credit
  always_comb begin
    vnet_ok = int'(bus.vnet_i) < N_VNET;
    base    = NP'(bus.vnet_i) * NP'(N_OF_VC);
    gv      = '0;
    elig    = '0;
    for (int l = 0; l < N_OF_VC; l++) begin
      gv      = base + NP'(l);
      elig[l] = vnet_ok && !busy_q[gv] && (credit_q[gv] != '0);
    end
  end

`ifdef NIC_VC_ALLOC_RR_EN
  logic [NRR-1:0] rr_q [N_VNET];
  logic [NRR-1:0] rr_cur;
  logic           found;

  // first eligible VC at or after the vnet's pointer
  always_comb begin
    sel_loc = '0;
    found   = 1'b0;
    rr_cur  = vnet_ok ? rr_q[bus.vnet_i] : '0;
    for (int off = 0; off < N_OF_VC; off++) begin
      if (!found && elig[(int'(rr_cur) + off) % N_OF_VC]) begin
        found   = 1'b1;
        sel_loc = NRR'((int'(rr_cur) + off) % N_OF_VC);
      end
    end
  end

  // pointer moves past the VC just granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_VNET; i++) rr_q[i] <= '0;
    end else if (grant) begin
      if (int'(sel_loc) == N_OF_VC - 1)
        rr_q[bus.vnet_i] <= '0;
      else
        rr_q[bus.vnet_i] <= sel_loc + NRR'(1);
    end
  end
`else
  // lowest-index eligible VC wins
  always_comb begin
    sel_loc = '0;
    for (int l = N_OF_VC - 1; l >= 0; l--)
      if (elig[l]) sel_loc = NRR'(l);
  end
`endif

  assign sel = base + NP'(sel_loc);

  // next state, grant and per-cycle send decision
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    send    = 1'b0;
    last    = (idx_q == len_q);
    unique case (state_q)
      IDLE: begin
        grant = bus.r_pkt_i && (|elig);
        if (grant && eff_len != NIX'(1)) state_d = SEND;
      end
      SEND: begin
        if (last) state_d = IDLE;
        else send = (credit_q[vc_q] != '0);
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // packet capture and flit output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_PACKET_LENGHT; k++) pkt_q[k] <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      vc_q       <= '0;
      out_link_q <= '0;
      valid_q    <= 1'b0;
      out_vc_q   <= '0;
    end else if (grant) begin
      for (int k = 0; k < MAX_PACKET_LENGHT; k++)
        pkt_q[k] <= bus.in_link_i[k*FLIT_WIDTH +: FLIT_WIDTH];
      len_q      <= eff_len;
      idx_q      <= NIX'(1);
      vc_q       <= sel;
      out_link_q <= bus.in_link_i[FLIT_WIDTH-1:0];
      valid_q    <= 1'b1;
      out_vc_q   <= sel;
    end else if (send) begin
      out_link_q <= pkt_q[idx_q];
      valid_q    <= 1'b1;
      idx_q      <= idx_q + NIX'(1);
    end else begin
      valid_q    <= 1'b0;
    end
  end

  // which VC consumes a credit and which gets allocated this cycle
  always_comb begin
    dec_vc   = grant ? sel : vc_q;
    dec_mask = '0;
    set_mask = '0;
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      dec_mask[v] = (grant || send) && (dec_vc == NP'(v));
      set_mask[v] = grant && (sel == NP'(v));
    end
  end

  // credit counters and busy flags; allocation beats a same-edge free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < N_TOT_OF_VC; v++)
        credit_q[v] <= N_BITS_CREDIT'(CREDIT_DEPTH);
      busy_q <= '0;
    end else begin
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
        if (bus.credit_signal_i[v] && !dec_mask[v]) begin
          if (credit_q[v] != N_BITS_CREDIT'(CREDIT_DEPTH))
            credit_q[v] <= credit_q[v] + N_BITS_CREDIT'(1);
        end else if (dec_mask[v] && !bus.credit_signal_i[v]) begin
          credit_q[v] <= credit_q[v] - N_BITS_CREDIT'(1);
        end
        if (set_mask[v])                busy_q[v] <= 1'b1;
        else if (bus.free_signal_i[v])  busy_q[v] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nic_vc_out_scheduler.sv
// Bench for nic_vc_out_scheduler: flit scoreboard plus scenario tasks.
// Expected VC choices follow NIC_VC_ALLOC_RR_EN when it is defined.
module tb_nic_vc_out_scheduler;
`ifdef NIC_VC_ALLOC_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int T_STALL = RR ? 3 : 2;
  localparam int T_RST   = RR ? 3 : 2;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  vc;
  } flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  flit_t exp_q[$];
  flit_t got;

  always #5 clk = ~clk;

  nic_vc_out_scheduler_if ifc ();

  nic_vc_out_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // scoreboard: every valid flit must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && ifc.is_valid_o === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL flit: got %h vc %0d, required no flit",
                 ifc.out_link_o, ifc.out_vc_o);
      end else begin
        got = exp_q.pop_front();
        if (ifc.out_link_o !== got.data || ifc.out_vc_o !== got.vc) begin
          n_bad++;
          $display("FAIL flit: got %h vc %0d, required %h vc %0d",
                   ifc.out_link_o, ifc.out_vc_o, got.data, got.vc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic offer(input int vnet, input int len, input int exp_vc,
                       input int max_wait, output int waited);
    logic [319:0] pkt;
    int eff;
    for (int k = 0; k < 5; k++) pkt[k*64 +: 64] = {$urandom, $urandom};
    ifc.r_pkt_i   = 1'b1;
    ifc.vnet_i    = 2'(vnet);
    ifc.pkt_len_i = 3'(len);
    ifc.in_link_i = pkt;
    waited = 0;
    forever begin
      #1;
      if (ifc.g_pkt_o === 1'b1) break;
      if (waited >= max_wait) break;
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (ifc.g_pkt_o !== 1'b1) begin
      n_bad++;
      $display("FAIL grant vnet%0d: g_pkt_o=%b after %0d cycles, required 1",
               vnet, ifc.g_pkt_o, waited);
      ifc.r_pkt_i = 1'b0;
    end else begin
      eff = (len == 0) ? 1 : (len > 5) ? 5 : len;
      for (int k = 0; k < eff; k++)
        exp_q.push_back('{data: pkt[k*64 +: 64], vc: 3'(exp_vc)});
      @(negedge clk);
      ifc.r_pkt_i = 1'b0;
      #2;
      n_cmp++;
      if (ifc.is_valid_o !== 1'b1) begin
        n_bad++;
        $display("FAIL head_latency: is_valid_o=%b, required 1",
                 ifc.is_valid_o);
      end
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d flits pending, required 0", exp_q.size());
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (ifc.is_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL after_tail: is_valid_o=%b, required 0", ifc.is_valid_o);
    end
  endtask

  task automatic pulse_credit(input logic [5:0] m, input int n);
    repeat (n) begin
      ifc.credit_signal_i = m;
      @(negedge clk);
      #2;
    end
    ifc.credit_signal_i = '0;
  endtask

  task automatic pulse_free(input logic [5:0] m);
    ifc.free_signal_i = m;
    @(negedge clk);
    #2;
    ifc.free_signal_i = '0;
  endtask

  task automatic check_stall(input string name, input int pending);
    n_cmp++;
    if (ifc.is_valid_o !== 1'b0 || exp_q.size() != pending) begin
      n_bad++;
      $display("FAIL %s: is_valid_o=%b pending=%0d, required 0 and %0d",
               name, ifc.is_valid_o, exp_q.size(), pending);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (ifc.is_valid_o !== 1'b0 || ifc.g_pkt_o !== 1'b0 ||
        ifc.vc_busy_o !== 6'b0 || ifc.out_vc_o !== 3'd0 ||
        ifc.out_link_o !== 64'd0) begin
      n_bad++;
      $display("FAIL reset: valid=%b g=%b busy=%b vc=%0d link=%h, required 0",
               ifc.is_valid_o, ifc.g_pkt_o, ifc.vc_busy_o, ifc.out_vc_o,
               ifc.out_link_o);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int w;
    offer(1, 3, 2, 0, w);
    drain(10);
    n_cmp++;
    if (ifc.vc_busy_o !== 6'b000100) begin
      n_bad++;
      $display("FAIL busy_basic: vc_busy_o=%b, required 000100",
               ifc.vc_busy_o);
    end
  endtask

  task automatic test_stall();
    int w;
    pulse_credit(6'b000100, 3);
    pulse_free(6'b000100);
    pulse_credit(6'b001100, 1);
    offer(1, 5, T_STALL, 0, w);
    repeat (3) begin
      @(negedge clk);
      #2;
    end
    n_cmp++;
    if (exp_q.size() != 1) begin
      n_bad++;
      $display("FAIL stall_count: pending=%0d, required 1", exp_q.size());
    end
    repeat (3) begin
      @(negedge clk);
      #2;
      check_stall("stall", 1);
    end
    pulse_credit(6'b1 << T_STALL, 1);
    check_stall("credit_wait", 1);
    drain(5);
  endtask

  task automatic test_same_cycle();
    int w;
    offer(0, 0, 0, 0, w);
    drain(5);
    offer(0, 1, 1, 0, w);
    drain(5);
    pulse_free(6'b000001);
    ifc.credit_signal_i = 6'b000001;
    offer(0, 1, 0, 0, w);
    ifc.credit_signal_i = '0;
    drain(5);
    pulse_free(6'b000001);
    offer(0, 7, 0, 0, w);
    repeat (2) begin
      @(negedge clk);
      #2;
    end
    n_cmp++;
    if (exp_q.size() != 2) begin
      n_bad++;
      $display("FAIL same_cycle_credit: pending=%0d, required 2",
               exp_q.size());
    end
    @(negedge clk);
    #2;
    check_stall("same_cycle_stall", 2);
    pulse_credit(6'b000001, 2);
    drain(10);
  endtask

  task automatic test_busy();
    int w;
    ifc.r_pkt_i   = 1'b1;
    ifc.vnet_i    = 2'd0;
    ifc.pkt_len_i = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (ifc.g_pkt_o !== 1'b0) begin
        n_bad++;
        $display("FAIL all_busy: g_pkt_o=%b cycle %0d, required 0",
                 ifc.g_pkt_o, i);
      end
      @(negedge clk);
      #2;
    end
    ifc.vnet_i = 2'd3;
    #1;
    n_cmp++;
    if (ifc.g_pkt_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_vnet: g_pkt_o=%b, required 0", ifc.g_pkt_o);
    end
    ifc.vnet_i        = 2'd0;
    ifc.free_signal_i = 6'b000010;
    #1;
    n_cmp++;
    if (ifc.g_pkt_o !== 1'b0) begin
      n_bad++;
      $display("FAIL free_early: g_pkt_o=%b, required 0", ifc.g_pkt_o);
    end
    @(negedge clk);
    #2;
    ifc.free_signal_i = '0;
    offer(0, 2, 1, 0, w);
    drain(5);
  endtask

  task automatic test_rr();
    int w;
    offer(2, 1, 4, 0, w);
    drain(5);
    pulse_free(6'b110000);
    offer(2, 1, RR ? 5 : 4, 0, w);
    drain(5);
  endtask

  task automatic test_back_to_back();
    int w, w2;
    pulse_free(6'b111111);
    pulse_credit(6'b111111, 4);
    offer(1, 2, 2, 0, w);
    offer(2, 2, 4, 5, w2);
    n_cmp++;
    if (w2 != 2) begin
      n_bad++;
      $display("FAIL b2b_gap: next grant after %0d cycles, required 2", w2);
    end
    drain(5);
  endtask

  task automatic test_reset_mid();
    int w;
    pulse_free(6'b111111);
    pulse_credit(6'b111111, 2);
    offer(1, 4, T_RST, 0, w);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ifc.is_valid_o !== 1'b0 || ifc.vc_busy_o !== 6'b0 ||
        ifc.g_pkt_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: valid=%b busy=%b g=%b, required 0",
               ifc.is_valid_o, ifc.vc_busy_o, ifc.g_pkt_o);
    end
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    offer(1, 5, 2, 0, w);
    repeat (3) begin
      @(negedge clk);
      #2;
    end
    n_cmp++;
    if (exp_q.size() != 1) begin
      n_bad++;
      $display("FAIL credits_after_reset: pending=%0d, required 1",
               exp_q.size());
    end
    @(negedge clk);
    #2;
    check_stall("reset_stall", 1);
    pulse_credit(6'b000100, 1);
    drain(5);
  endtask

  initial begin
    ifc.r_pkt_i         = 1'b0;
    ifc.vnet_i          = '0;
    ifc.pkt_len_i       = '0;
    ifc.in_link_i       = '0;
    ifc.credit_signal_i = '0;
    ifc.free_signal_i   = '0;
    test_reset();
    test_basic();
    test_stall();
    test_same_cycle();
    test_busy();
    test_rr();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    #2;
    check_stall("final_idle", 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
